// File: rtl/chunked_adder_sequencer.sv
// Chunked wide adder: one shared NO_BITS-wide ripple Adder is applied to successive
// operand chunks, LSB chunk first, one chunk per clock, with the carry held in a register
// between cycles. A start/busy/done handshake frames each operation.

// Plain ripple-carry adder primitive: out = a + b + ci, with out[N] the carry-out.
module Adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N:0]   out
);

  logic c;

  // Bit-serial carry ripple through N full adders.
  always_comb begin
    out = '0;
    c   = ci;
    for (int i = 0; i < int'(N); i++) begin
      out[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    out[N] = c;
  end

endmodule

module chunked_adder_sequencer #(
  parameter int unsigned NO_BITS   = 8,
  parameter int unsigned NO_CHUNKS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NO_BITS*NO_CHUNKS-1:0]   A,
  input  logic [NO_BITS*NO_CHUNKS-1:0]   B,
  input  logic                           cin,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic [NO_BITS*NO_CHUNKS:0]     sum
);

  localparam int unsigned W  = NO_BITS * NO_CHUNKS;
  localparam int unsigned CW = (NO_CHUNKS > 1) ? $clog2(NO_CHUNKS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry_reg;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   part_q;
  logic [W:0]     sum_q;

  logic [31:0]    base;
  logic [NO_BITS-1:0] a_chunk;
  logic [NO_BITS-1:0] b_chunk;
  logic [NO_BITS:0]   add_out;
  logic [W-1:0]   part_merged;
  logic           accept;
  logic           last_chunk;

  assign base       = 32'(cnt) * NO_BITS;
  assign a_chunk    = a_reg[base +: NO_BITS];
  assign b_chunk    = b_reg[base +: NO_BITS];
  assign accept     = (state_q != StRun) && start;
  assign last_chunk = (cnt == CW'(NO_CHUNKS - 1));

  Adder #(
    .N(NO_BITS)
  ) u_adder (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_reg),
    .out(add_out)
  );

  // Partial result with the chunk being added this cycle already merged in, so the final
  // edge can write the complete sum without waiting one more cycle.
  always_comb begin
    part_merged = part_q;
    part_merged[base +: NO_BITS] = add_out[NO_BITS-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE behaves like IDLE for accepting a new request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start ? StRun : StIdle;
      StRun:   state_d = last_chunk ? StDone : StRun;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  ready = 1'b1;
      StRun:   busy  = 1'b1;
      StDone: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operand capture on accept, one chunk per RUN edge, sum written on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      part_q    <= '0;
      sum_q     <= '0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      carry_reg <= cin;
      cnt       <= '0;
    end else if (state_q == StRun) begin
      part_q    <= part_merged;
      carry_reg <= add_out[NO_BITS];
      cnt       <= cnt + CW'(1);
      if (last_chunk) begin
        sum_q <= {add_out[NO_BITS], part_merged};
      end
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed-plus-random bench for chunked_adder_sequencer (8x4 and 8x1 instances).
module tb_chunked_adder_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        cin;
  logic        ready, busy, done;
  logic [32:0] sum;

  logic        start1;
  logic [7:0]  A1, B1;
  logic        cin1;
  logic        ready1, busy1, done1;
  logic [8:0]  sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder_sequencer #(
    .NO_BITS  (8),
    .NO_CHUNKS(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .ready(ready),
    .busy (busy),
    .done (done),
    .sum  (sum)
  );

  chunked_adder_sequencer #(
    .NO_BITS  (8),
    .NO_CHUNKS(1)
  ) dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .A    (A1),
    .B    (B1),
    .cin  (cin1),
    .ready(ready1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  // Full operation; with noisy=1 inputs are scrambled and start pulsed during RUN.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input bit noisy);
    logic [32:0] exp;
    logic [32:0] prev;
    exp   = ref_sum(a, b, c);
    prev  = sum;
    A     = a;
    B     = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_nodone", 64'(done), 64'd0);
      chk("run_ready", 64'(ready), 64'd0);
      chk("run_sum_hold", 64'(sum), 64'(prev));
      if (noisy) begin
        A     = $urandom;
        B     = $urandom;
        cin   = 1'($urandom);
        start = (i < 3) ? 1'($urandom) : 1'b0;
      end
      tick();
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_ready", 64'(ready), 64'd1);
    chk("done_sum", 64'(sum), 64'(exp));
    tick();
    chk("after_done_low", 64'(done), 64'd0);
    chk("after_sum_hold", 64'(sum), 64'(exp));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    A1     = '0;
    B1     = '0;
    cin1   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);

    // Full carry ripple across all chunks.
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("ripple_sum", 64'(sum), 64'h1_0000_0000);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    chk("cin_sum", 64'(sum), 64'h0_2345_678A);
    tick();
    chk("idle_sum_hold", 64'(sum), 64'h0_2345_678A);

    // Starts and operand changes during RUN are ignored.
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    chk("ignored_start_sum", 64'(sum), 64'h0_0000_0100);

    // Reset in the second RUN cycle aborts.
    A     = 32'h8000_0000;
    B     = 32'h8000_0000;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_sum", 64'(sum), 64'd0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    chk("post_abort_sum", 64'(sum), 64'h1_0000_0000);

    // Back-to-back with start held high.
    A     = 32'd1;
    B     = 32'd2;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    for (int t = 1; t <= 4; t++) begin
      chk("b2b_first_wait", 64'(done), 64'd0);
      tick();
    end
    chk("b2b_first_done", 64'(done), 64'd1);
    chk("b2b_first_sum", 64'(sum), 64'h3);
    A = 32'd3;
    B = 32'd4;
    tick();
    for (int t = 1; t <= 4; t++) begin
      chk("b2b_second_wait", 64'(done), 64'd0);
      if (t == 4) start = 1'b0;
      tick();
    end
    chk("b2b_second_done", 64'(done), 64'd1);
    chk("b2b_second_sum", 64'(sum), 64'h7);
    tick();

    // Random operations with noise during RUN.
    for (int n = 0; n < 24; n++) begin
      do_op($urandom, $urandom, 1'($urandom), bit'($urandom));
    end
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("max_sum", 64'(sum), 64'h1_FFFF_FFFF);

    // Single-chunk instance.
    A1     = 8'hFF;
    B1     = 8'hFF;
    cin1   = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("nc1_busy", 64'(busy1), 64'd1);
    chk("nc1_nodone", 64'(done1), 64'd0);
    tick();
    chk("nc1_done", 64'(done1), 64'd1);
    chk("nc1_sum", 64'(sum1), 64'h1FF);
    for (int n = 0; n < 8; n++) begin
      logic [8:0] e1;
      A1     = 8'($urandom);
      B1     = 8'($urandom);
      cin1   = 1'($urandom);
      e1     = {1'b0, A1} + {1'b0, B1} + {8'd0, cin1};
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      chk("nc1_rand_done", 64'(done1), 64'd1);
      chk("nc1_rand_sum", 64'(sum1), 64'(e1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
